// File: rtl/regfile.sv
// General-purpose register file: MEM/WB write-back sink, two combinational read ports for ID.
// Latency: writes land on the posedge and are visible from the next cycle; reads are combinational.
// No backpressure: every write and read completes in its own cycle. Optional macro: REGFILE_WRITE_BYPASS_EN.
module regfile #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re1,
    input  logic [ADDR_W-1:0] i_raddr1,
    output logic [DATA_W-1:0] o_rdata1,
    input  logic              i_re2,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata2
);

    logic [DATA_W-1:0] r_regs [REG_NUM];

    // Writes to register 0 never reach the array, so it stays zero after the first reset.
    logic w_wr_ok;
    assign w_wr_ok = i_we && (i_waddr != '0);

`ifdef REGFILE_WRITE_BYPASS_EN
    // A read that matches the write retiring this cycle takes the incoming data,
    // letting ID consume a WB result without a stall.
    logic w_byp1;
    logic w_byp2;
    assign w_byp1 = w_wr_ok && (i_waddr == i_raddr1);
    assign w_byp2 = w_wr_ok && (i_waddr == i_raddr2);
`endif

    // Single-edge clear on reset; a write colliding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Read port 1: reset, disable and address 0 all force zero ahead of any data path.
    always_comb begin
        o_rdata1 = '0;
        if (rst || !i_re1 || (i_raddr1 == '0)) begin
            o_rdata1 = '0;
`ifdef REGFILE_WRITE_BYPASS_EN
        end else if (w_byp1) begin
            o_rdata1 = i_wdata;
`endif
        end else begin
            o_rdata1 = r_regs[i_raddr1];
        end
    end

    // Read port 2: identical priority to port 1.
    always_comb begin
        o_rdata2 = '0;
        if (rst || !i_re2 || (i_raddr2 == '0)) begin
            o_rdata2 = '0;
`ifdef REGFILE_WRITE_BYPASS_EN
        end else if (w_byp2) begin
            o_rdata2 = i_wdata;
`endif
        end else begin
            o_rdata2 = r_regs[i_raddr2];
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vectors plus a short random soak.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// Expected values are hand-derived constants or come from a small array model.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] m [32];

    regfile #(.DATA_W(32), .ADDR_W(5), .REG_NUM(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_we     (we),
        .i_waddr  (waddr),
        .i_wdata  (wdata),
        .i_re1    (re1),
        .i_raddr1 (raddr1),
        .o_rdata1 (rdata1),
        .i_re2    (re2),
        .i_raddr2 (raddr2),
        .o_rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // advance past the next posedge, keeping the model in step with the inputs it saw
    task automatic cyc();
        if (rst) begin
            for (int i = 0; i < 32; i++) m[i] = 32'h0;
        end else if (we && waddr != 5'd0) begin
            m[waddr] = wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] ra);
        if (rst) return 32'h0;
        if (!re) return 32'h0;
        if (ra == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (we && waddr == ra) return wdata;
`endif
        return m[ra];
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd4;
        #1;
        smp();
        chk("rst_cycle_rd1", rdata1, 32'h0);
        chk("rst_cycle_rd2", rdata2, 32'h0);
        cyc();
        rst = 1'b0;

        // T1: fill 1..31, confirm contents, then reset clears everything
        re1 = 1'b0; re2 = 1'b0;
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'hA5A5_0000 + 32'(i);
            cyc();
        end
        we = 1'b0;
        re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd31;
        smp();
        chk("t1_fill_r3", rdata1, 32'hA5A5_0003);
        chk("t1_fill_r31", rdata2, 32'hA5A5_001F);
        cyc();
        rst = 1'b1;
        smp();
        chk("t1_rst_rd1", rdata1, 32'h0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i);
            smp();
            chk($sformatf("t1_clr_p1_%0d", i), rdata1, 32'h0);
            chk($sformatf("t1_clr_p2_%0d", 31 - i), rdata2, 32'h0);
            cyc();
        end

        // T2: register 0 ignores writes, same cycle and after
        we = 1'b1; waddr = 5'd0; wdata = 32'hDEAD_BEEF;
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
        smp();
        chk("t2_same_rd1", rdata1, 32'h0);
        chk("t2_same_rd2", rdata2, 32'h0);
        cyc();
        we = 1'b0;
        smp();
        chk("t2_next_rd1", rdata1, 32'h0);
        cyc();

        // T3: basic write then read on both ports, then port-2 disable
        we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678;
        re1 = 1'b0; re2 = 1'b0;
        cyc();
        we = 1'b0; re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
        smp();
        chk("t3_rd1", rdata1, 32'h1234_5678);
        chk("t3_rd2", rdata2, 32'h1234_5678);
        cyc();
        re2 = 1'b0;
        smp();
        chk("t3_rd1_re2off", rdata1, 32'h1234_5678);
        chk("t3_rd2_disabled", rdata2, 32'h0);
        cyc();

        // T4: same-cycle write/read of register 7 on both ports
        we = 1'b1; waddr = 5'd7; wdata = 32'h1111_1111;
        cyc();
        we = 1'b1; waddr = 5'd7; wdata = 32'h2222_2222;
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
        smp();
`ifdef REGFILE_WRITE_BYPASS_EN
        chk("t4_byp_rd1", rdata1, 32'h2222_2222);
        chk("t4_byp_rd2", rdata2, 32'h2222_2222);
`else
        chk("t4_old_rd1", rdata1, 32'h1111_1111);
        chk("t4_old_rd2", rdata2, 32'h1111_1111);
`endif
        cyc();
        we = 1'b0;
        smp();
        chk("t4_next_rd1", rdata1, 32'h2222_2222);
        chk("t4_next_rd2", rdata2, 32'h2222_2222);
        cyc();

        // T5: reset colliding with a write discards it and clears earlier data
        rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'hFFFF_FFFF;
        re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd7;
        smp();
        chk("t5_rst_rd1", rdata1, 32'h0);
        chk("t5_rst_rd2", rdata2, 32'h0);
        cyc();
        rst = 1'b0; we = 1'b0;
        smp();
        chk("t5_after_r9", rdata1, 32'h0);
        chk("t5_after_r7", rdata2, 32'h0);
        cyc();
        we = 1'b1; waddr = 5'd9; wdata = 32'h0BAD_F00D;
        cyc();
        we = 1'b0; raddr1 = 5'd9; raddr2 = 5'd5;
        smp();
        chk("t5_rewrite_r9", rdata1, 32'h0BAD_F00D);
        chk("t5_r5_cleared", rdata2, 32'h0);
        cyc();

        // T6: random soak against the model
        for (int c = 0; c < 3000; c++) begin
            rst    = ($urandom_range(0, 127) == 0);
            we     = 1'($urandom_range(0, 1));
            waddr  = 5'($urandom_range(0, 31));
            wdata  = $urandom;
            re1    = ($urandom_range(0, 7) != 0);
            re2    = ($urandom_range(0, 7) != 0);
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            smp();
            chk("t6_rd1", rdata1, exp_rd(re1, raddr1));
            chk("t6_rd2", rdata2, exp_rd(re2, raddr2));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
